dxm_mux_arb: RTL and testbench

- Round-robin arbiter and select sequencer for a shared datapath built from dxm_mux trees.
- N requesters (TRNG sample path, self-test, debug readout) compete for one shared resource.
- The arbiter grants one owner at a time and drives a stable binary select to the mux tree.
- It holds the grant until the owner releases it, then rotates priority.

---
 rtl/dxm_mux_arb_pkg.sv | 12 +
 rtl/dxm_rr_pick.sv | 24 ++
 rtl/dxm_mux_arb.sv | 81 ++++++++
 tb/tb_dxm_mux_arb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dxm_mux_arb_pkg.sv
// dxm_mux_arb_pkg: shared state encodings, counter width and clog2 helper for the dxm arbiter
package dxm_mux_arb_pkg;
   localparam logic ARB_IDLE  = 1'b0;
   localparam logic ARB_GRANT = 1'b1;
   localparam int   TO_CNT_W  = 16;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/dxm_rr_pick.sv
// dxm_rr_pick: combinational rotate-priority picker, first set bit at or above ptr with wrap
module dxm_rr_pick import dxm_mux_arb_pkg::*; #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] win,
   output logic [W-1:0] idx,
   output logic         any
);
   // scan offsets from farthest to nearest so the nearest hit to ptr is the one kept
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[(int'(ptr) + i) % N]) begin
            idx = W'((int'(ptr) + i) % N);
            any = 1'b1;
         end
      end
      win = any ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/dxm_mux_arb.sv
// dxm_mux_arb: round-robin grant holder driving the dxm_mux select; DXM_ARB_TIMEOUT_EN adds forced release
module dxm_mux_arb import dxm_mux_arb_pkg::*; #(
   parameter int NUM_REQ     = 4,
   parameter int SEL_W       = 2,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               rel,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               timeout_err
);
   logic               state;
   logic               idle;
   logic [SEL_W-1:0]   ptr;
   logic [SEL_W-1:0]   nptr;
   logic [SEL_W-1:0]   pick_ptr;
   logic [SEL_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] pick_oh;
   logic               pick_any;
   logic               rel_now;
   logic               to_hit;
   logic               rls;

   assign idle     = (state == ARB_IDLE);
   assign busy     = !idle;
   assign nptr     = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
   assign rel_now  = !idle && (rel || !req[sel]);
   assign rls      = rel_now || to_hit;
   // on handoff the releasing owner is masked so it can only win again from IDLE
   assign cand     = idle ? req : (req & ~(NUM_REQ'(1) << sel));
   assign pick_ptr = idle ? ptr : nptr;

   dxm_rr_pick #(.N(NUM_REQ), .W(SEL_W)) u_pick (
      .cand (cand),
      .ptr  (pick_ptr),
      .win  (pick_oh),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // grant from IDLE or hand off on release; sel keeps the last owner when going idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         sel       <= '0;
      end else if (idle ? pick_any : rls) begin
         if (!idle) ptr <= nptr;
         state     <= pick_any ? ARB_GRANT : ARB_IDLE;
         gnt       <= pick_oh;
         gnt_valid <= pick_any;
         if (pick_any) sel <= pick_idx;
      end
   end

`ifdef DXM_ARB_TIMEOUT_EN
   logic [TO_CNT_W-1:0] cnt;
   assign to_hit = !idle && !rel_now && (cnt == TO_CNT_W'(TIMEOUT_CYC - 1));
   // count held-grant cycles; any grant change or release restarts from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         cnt         <= (!idle && !rls) ? cnt + 1'b1 : '0;
         timeout_err <= to_hit;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_dxm_mux_arb.sv
// tb_dxm_mux_arb: directed and random checks of dxm_mux_arb against a rule-level reference model
module tb_dxm_mux_arb;
   localparam int N  = 4;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         rel = 1'b0;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   sel;
   logic         busy;
   logic         timeout_err;

   int checks = 0;
   int failures = 0;

   int m_own, m_ptr, m_sel, m_cnt;
   bit m_terr;
   bit to_en;

   dxm_mux_arb #(.NUM_REQ(N), .SEL_W(2), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .rel         (rel),
      .gnt         (gnt),
      .gnt_valid   (gnt_valid),
      .sel         (sel),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [N-1:0] c, input int p);
      for (int i = 0; i < N; i++) if (c[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_ptr = 0; m_sel = 0; m_cnt = 0; m_terr = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] r, input bit rl);
      bit gone, forced;
      int w;
      logic [N-1:0] c;
      m_terr = 0;
      if (m_own < 0) begin
         w = first_from(r, m_ptr);
         if (w >= 0) begin m_own = w; m_sel = w; m_cnt = 0; end
      end else begin
         gone = rl || !r[m_own];
         forced = to_en && !gone && (m_cnt == TO - 1);
         if (gone || forced) begin
            m_ptr = (m_own + 1) % N;
            c = r;
            c[m_own] = 1'b0;
            w = first_from(c, m_ptr);
            m_own = w;
            if (w >= 0) m_sel = w;
            m_cnt = 0;
            m_terr = forced;
         end else m_cnt++;
      end
   endtask

   task automatic chk_model(input string tag);
      logic [N-1:0] eg;
      eg = (m_own < 0) ? '0 : (N'(1) << m_own);
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_own >= 0));
      chk({tag, ".busy"}, 32'(busy), 32'(m_own >= 0));
      chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
      chk({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
   endtask

   task automatic step(input logic [N-1:0] r, input bit rl, input string tag);
      req = r;
      rel = rl;
      @(posedge clk);
      model_edge(r, rl);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      rel = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      chk_model("reset");
      rst_n = 1'b1;
   endtask

   initial begin
`ifdef DXM_ARB_TIMEOUT_EN
      to_en = 1;
`else
      to_en = 0;
`endif
      model_reset();
      do_reset();

      // grant latency and gapless handoff
      step(4'b0110, 0, "t1_grant");
      chk("t1_gnt", 32'(gnt), 32'h2);
      chk("t1_sel", 32'(sel), 32'd1);
      step(4'b0110, 1, "t1_handoff");
      chk("t1_gnt2", 32'(gnt), 32'h4);
      chk("t1_sel2", 32'(sel), 32'd2);

      // owner drops req and pulses rel together, nobody else waiting
      step(4'b0000, 1, "t3_release");
      chk("t3_gnt", 32'(gnt), 32'h0);
      chk("t3_busy", 32'(busy), 32'd0);
      chk("t3_sel_hold", 32'(sel), 32'd2);

      // lone requester re-wins only after one idle cycle
      step(4'b1000, 0, "t4_grant");
      chk("t4_gnt", 32'(gnt), 32'h8);
      step(4'b1000, 1, "t4_rel");
      chk("t4_idle", 32'(gnt), 32'h0);
      step(4'b1000, 0, "t4_regrant");
      chk("t4_gnt2", 32'(gnt), 32'h8);

      // asynchronous reset between edges
      step(4'b1000, 0, "t5_hold");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t5_gnt", 32'(gnt), 32'h0);
      chk("t5_sel", 32'(sel), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step(4'b1010, 0, "t5_first");
      chk("t5_lowest", 32'(gnt), 32'h2);

      // full contention rotates 0,1,2,3,0 with 3-cycle grants
      do_reset();
      step(4'b1111, 0, "t2_g0");
      chk("t2_sel0", 32'(sel), 32'd0);
      for (int g = 1; g <= 4; g++) begin
         step(4'b1111, 0, "t2_h1");
         step(4'b1111, 0, "t2_h2");
         step(4'b1111, 1, "t2_rot");
         chk("t2_order", 32'(sel), 32'(g % N));
      end

      // owner never releases: forced release only when timeout is compiled in
      do_reset();
      step(4'b0011, 0, "t6_grant");
      for (int c = 0; c < 110; c++) step(4'b0011, 0, "t6_hold");
`ifndef DXM_ARB_TIMEOUT_EN
      chk("t6_unbounded", 32'(gnt), 32'h1);
`endif

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 500; c++)
         step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
